// File: rtl/prog_loader.sv
// Program loader: parses framed byte stream (SYNC, LEN, LE data words, CHK), writes words
// to instruction RAM and keeps the CPU core held in reset until a checksum-valid image lands.
module prog_loader #(
  parameter int          ADDR_W     = 16,
  parameter int          START_ADDR = 0,
  parameter int          ADDR_STEP  = 4,
  parameter int          MAX_WORDS  = 4096,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_ram_en,
  output logic [ADDR_W-1:0] wr_ram_addr,
  output logic [31:0]       wr_ram_data,
  output logic              cpu_hold,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [2:0]        o_dbg_state
);

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready are both high;
  // in_ready is low only during the single WRITE cycle, in_valid low simply stalls.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0] START_A   = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] STEP_A    = ADDR_W'(ADDR_STEP);
  localparam logic [16:0]       MAX_W17   = 17'(MAX_WORDS);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [7:0]        r_sum;
  logic [7:0]        r_len_lo;
  logic [15:0]       r_words_left;
  logic [1:0]        r_k;
  logic              w_acc;
  logic [15:0]       w_len;

  assign w_acc = in_valid && in_ready;
  assign w_len = {in_data, r_len_lo};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR:
        if (w_acc && in_data == SYNC_BYTE) w_next = S_LEN_LO;
      S_LEN_LO:
        if (w_acc) w_next = S_LEN_HI;
      S_LEN_HI:
        if (w_acc) begin
          if ({1'b0, w_len} > MAX_W17) w_next = S_ERROR;
          else if (w_len == 16'd0)     w_next = S_CHECK;
          else                         w_next = S_DATA;
        end
      S_DATA:
        if (w_acc && r_k == 2'd3) w_next = S_WRITE;
      // words_left is decremented on this same edge, so 1 here means the frame is complete
      S_WRITE:
        w_next = (r_words_left == 16'd1) ? S_CHECK : S_DATA;
      S_CHECK:
        if (w_acc) w_next = (in_data == r_sum) ? S_DONE : S_ERROR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr       <= START_A;
      r_data       <= 32'd0;
      r_sum        <= 8'd0;
      r_len_lo     <= 8'd0;
      r_words_left <= 16'd0;
      r_k          <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR:
          if (w_acc && in_data == SYNC_BYTE) begin
            r_sum  <= 8'd0;
            r_addr <= START_A;
            r_k    <= 2'd0;
          end
        S_LEN_LO:
          if (w_acc) begin
            r_len_lo <= in_data;
            r_sum    <= r_sum + in_data;
          end
        S_LEN_HI:
          if (w_acc) begin
            r_words_left <= w_len;
            r_sum        <= r_sum + in_data;
          end
        S_DATA:
          if (w_acc) begin
            r_data[{r_k, 3'b000} +: 8] <= in_data;
            r_sum                      <= r_sum + in_data;
            r_k                        <= r_k + 2'd1;
          end
        S_WRITE: begin
          r_addr       <= r_addr + STEP_A;
          r_words_left <= r_words_left - 16'd1;
        end
        default: ;
      endcase
    end
  end

  // All status outputs are pure state decodes, so reset restores them on the next edge.
  assign in_ready    = (r_state != S_WRITE);
  assign wr_ram_en   = (r_state == S_WRITE);
  assign wr_ram_addr = r_addr;
  assign wr_ram_data = r_data;
  assign cpu_hold    = (r_state != S_DONE);
  assign load_busy   = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) || (r_state == S_DATA) ||
                       (r_state == S_WRITE)  || (r_state == S_CHECK);
  assign load_done   = (r_state == S_DONE);
  assign load_err    = (r_state == S_ERROR);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames sent byte by byte, RAM strobes captured at negedge
// and compared against hand-computed (addr, data) pairs.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_ram_en;
  logic [15:0] wr_ram_addr;
  logic [31:0] wr_ram_data;
  logic        cpu_hold;
  logic        load_busy;
  logic        load_done;
  logic        load_err;
  logic [2:0]  o_dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [47:0] exp_q[$];
  logic [47:0] obs_q[$];
  logic        obs_rdy_q[$];
  logic [7:0]  fb[$];

  prog_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_ram_en(wr_ram_en), .wr_ram_addr(wr_ram_addr), .wr_ram_data(wr_ram_data),
    .cpu_hold(cpu_hold), .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
    .o_dbg_state(o_dbg_state)
  );

  // clock / strobe capture
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_ram_en) begin
      obs_q.push_back({wr_ram_addr, wr_ram_data});
      obs_rdy_q.push_back(in_ready);
    end
  end

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
    n_checks++;
    if (act !== req) $display("FAIL %s: got %0h expected %0h", name, act, req);
    else n_pass++;
  endtask

  // driver tasks (all called from posedge+1 phase)
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    guard = 0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 10) begin @(posedge clk); #1; guard++; end
    n_checks++;
    if (guard >= 10) $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 10 cycles");
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_fb(input int gap);
    while (fb.size() > 0) send_byte(fb.pop_front(), gap);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic score(input string name);
    chk({name, "_count"}, 48'(obs_q.size()), 48'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      chk({name, "_word"}, obs_q.pop_front(), exp_q.pop_front());
      chk({name, "_rdy_at_strobe"}, 48'(obs_rdy_q.pop_front()), 48'd0);
    end
    exp_q.delete(); obs_q.delete(); obs_rdy_q.delete();
  endtask

  task automatic chk_status(input string name, input logic busy, input logic done,
                            input logic err, input logic hold);
    chk({name, "_busy"}, 48'(load_busy), 48'(busy));
    chk({name, "_done"}, 48'(load_done), 48'(done));
    chk({name, "_err"},  48'(load_err),  48'(err));
    chk({name, "_hold"}, 48'(cpu_hold),  48'(hold));
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 48'(in_ready), 48'd1);
    chk("reset_wr_en",    48'(wr_ram_en), 48'd0);
    chk("reset_addr",     48'(wr_ram_addr), 48'd0);
    chk("reset_data",     48'(wr_ram_data), 48'd0);
    chk("reset_state",    48'(o_dbg_state), 48'd0);
    chk_status("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_word();
    fb = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14};
    exp_q.push_back({16'h0000, 32'h0000_0013});
    send_fb(0);
    score("single");
    chk_status("single", 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_two_words();
    send_byte(8'hA5, 0);
    chk_status("restart", 1'b1, 1'b0, 1'b0, 1'b1);
    fb = '{8'h02, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h84};
    exp_q.push_back({16'h0000, 32'h0000_006F});
    exp_q.push_back({16'h0004, 32'h0000_0013});
    send_fb(0);
    score("two");
    chk_status("two", 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_bad_checksum();
    fb = '{8'hA5, 8'h02, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h85};
    exp_q.push_back({16'h0000, 32'h0000_006F});
    exp_q.push_back({16'h0004, 32'h0000_0013});
    send_fb(0);
    score("badchk");
    chk_status("badchk", 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_zero_len();
    fb = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_fb(0);
    score("zero");
    chk_status("zero", 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_too_long();
    fb = '{8'hA5, 8'h01, 8'h10};
    send_fb(0);
    score("toolong");
    chk_status("toolong", 1'b0, 1'b0, 1'b1, 1'b1);
    // sync value inside the data must not resync; words assemble little-endian
    fb = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h4B};
    exp_q.push_back({16'h0000, 32'h0000_A5A5});
    send_fb(0);
    score("after_toolong");
    chk_status("after_toolong", 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    fb = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    while (fb.size() > 0) send_byte(fb.pop_front(), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_status("midreset", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("midreset_in_ready", 48'(in_ready), 48'd1);
    chk("midreset_addr", 48'(wr_ram_addr), 48'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    score("midreset");
    // full frame with stalls between bytes
    fb = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
           8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA0};
    exp_q.push_back({16'h0000, 32'h0403_0201});
    exp_q.push_back({16'h0004, 32'hA5A5_A5A5});
    send_fb(2);
    score("reload");
    chk_status("reload", 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_words();
    test_bad_checksum();
    test_zero_len();
    test_too_long();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
